fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of two, at least 2.
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have flush  input  1  discard all queued and incoming entries (branch/exception redirect).
REQ-005 SHALL have in_valid  input  1  fetch stage presents a PC/instruction pair.
REQ-006 SHALL have in_pc  input  32  PC of the fetched instruction.
REQ-007 SHALL have in_instr  input  32  instruction word read at in_pc.
REQ-008 SHALL have in_ready  output  1  queue can accept; drives the PC register write-enable upstream.
REQ-009 SHALL have out_valid  output  1  head entry valid for decode.
REQ-010 SHALL have out_pc  output  32  PC of head entry.
REQ-011 SHALL have out_instr  output  32  instruction of head entry.
REQ-012 SHALL have out_exc  output  1  head entry carries an instruction-fetch address error.
REQ-013 SHALL have out_ready  input  1  decode consumes head entry this cycle.
REQ-014 SHALL have count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-016 SHALL drive in_ready = (count != DEPTH), independent of out_ready (no combinational ready path).
REQ-017 SHALL drive out_valid = (count != 0); outputs read head entry combinationally (first-word fall-through).
REQ-018 SHALL make a pushed entry visible on out_* the cycle after the push edge (1-cycle latency when empty).
REQ-019 SHALL keep count unchanged on simultaneous push and pop; full queue with pop accepts no push in that cycle (in_ready already low).
REQ-020 SHALL drive out_pc = 0, out_instr = 0, out_exc = 0 when empty.
REQ-021 SHALL set exc for a pushed entry when in_pc[1:0] != 0, in_pc < 0x0000_3000, or in_pc > 0x0000_6FFC; such entries store instr = 0x0000_0000 (nop).
REQ-022 SHALL wrap read/write pointers modulo DEPTH; count saturates at neither end (over/underflow impossible by REQ-015/016).
REQ-023 SHALL on flush set count, read and write pointers to 0 next edge; same-cycle push and pop are both discarded.
REQ-024 SHALL never reorder entries; pop order equals push order.

Reset
REQ-025 SHALL on reset clear count and pointers to 0, giving out_valid = 0, in_ready = 1, out_* = 0 next cycle.
REQ-026 SHALL give reset priority over flush, push and pop, including mid-operation with a full queue.
REQ-027 SHALL not require storage array contents to be reset.

Structure
REQ-028 SHALL take PC_BASE = 0x0000_3000, PC_LIMIT = 0x0000_6FFC and NOP = 0x0000_0000 from shared package cpu_pkg.
REQ-029 SHALL place the address-error check in one combinational sub-module, pc_range_check (in: pc 32; out: exc 1).
REQ-030 SHALL store pc, instr and exc per entry as one packed record type defined in cpu_pkg.

Verification
REQ-031 SHALL cover: empty queue, push pc=0x3000 instr=0x3C010001 with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, count=1.
REQ-032 SHALL cover: push 0x3000,0x3004,0x3008,0x300C with out_ready=0 -> count=4, in_ready=0; fifth push ignored; then pops return the four PCs in order.
REQ-033 SHALL cover: count=2, push and pop same cycle -> count stays 2, head advances from 0x3000 to 0x3004.
REQ-034 SHALL cover: push pc=0x3002 and pc=0x7000 -> both entries out_exc=1, out_instr=0x00000000.
REQ-035 SHALL cover: count=3, flush with in_valid=1 pc=0x3010 -> next cycle count=0, out_valid=0, 0x3010 not stored.
REQ-036 SHALL cover: full queue, reset with flush, in_valid and out_ready all high -> next cycle count=0, in_ready=1, out_pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU constants and types. Holds the legal instruction-fetch
//            window and the entry record stored by the fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Legal fetch window; the limit is the last word-aligned PC allowed.
    localparam logic [31:0] PC_BASE  = 32'h0000_3000;
    localparam logic [31:0] PC_LIMIT = 32'h0000_6FFC;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // One fetch-queue entry: PC, instruction word and fetch-address-error flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fq_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_range_check.sv
`default_nettype none
// ============================================================================
// Module   : pc_range_check
// Purpose  : Combinational instruction-fetch address-error check. Flags a PC
//            that is not word aligned or falls outside [PC_BASE, PC_LIMIT].
// Ports    : pc  (in, 32) - fetch address under test
//            exc (out, 1) - address error detected
// Revision : 1.0 - initial release
// ============================================================================
module pc_range_check
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    output logic        exc
);

    assign exc = (pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT);

endmodule : pc_range_check
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : First-word-fall-through queue between instruction fetch and
//            decode. Each entry carries PC, instruction and a fetch-address
//            error flag; faulting entries store a NOP instead of the word.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            flush           - discard all queued and incoming entries
//            in_valid/in_pc/in_instr/in_ready   - fetch-side handshake
//            out_valid/out_pc/out_instr/out_exc/out_ready - decode side
//            count           - number of occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_exc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    fq_entry_t          mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q,  count_d;

    logic               push;
    logic               pop;
    logic               pc_exc;
    fq_entry_t          new_entry;
    fq_entry_t          head;

    pc_range_check u_pc_range_check (
        .pc  (in_pc),
        .exc (pc_exc)
    );

    // Ready depends only on occupancy, so there is no combinational path
    // from out_ready back to in_ready.
    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        new_entry.pc    = in_pc;
        new_entry.exc   = pc_exc;
        new_entry.instr = pc_exc ? NOP : in_instr;
    end

    // Head is presented combinationally; forced to zero when empty so stale
    // storage never leaks onto the decode interface.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (!out_valid) begin
            head = '0;
        end
    end

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_exc   = head.exc;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule : fetch_queue
`default_nettype wire
